// File: rtl/sia_pkg.sv
// Shared definitions for the SIA serial blocks.
// Holds the receive engine state encoding and the common frame/baud constants.
// No ports: imported by sia_rxq (and the transmit side) with import sia_pkg::*.
package sia_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_DATA   = 2'd2,
        ST_WAITHI = 2'd3
    } rx_state_t;

    // 8 data bits, no parity, 1 stop bit: start + 8 + stop.
    localparam logic [4:0] SIA_BITS_8N1 = 5'd10;

    // Bit period minus one for 1 Mbps from a 50 MHz clock.
    localparam int unsigned SIA_BAUD_1M_AT_50M = 49;

endpackage

// File: rtl/sia_fifo.sv
// Show-ahead FIFO shared by the SIA transmit and receive queues.
// Ports: clk/rst (async active-high), push/wdata write port, pop read strobe,
//        rdata head word (zero when empty), full/empty status flags.
module sia_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (count == '0);
    // count never exceeds DEPTH, so its top bit alone marks full.
    assign full  = count[DEPTH_BITS];

    // A pop on an empty FIFO is dropped; a push into a full FIFO is
    // accepted only when a pop frees the head slot on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (DEPTH_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Storage is not reset, so the head is masked while empty.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sia_rxq.sv
// SIA receive queue: oversamples rxd_i, validates start bits, assembles frames
// LSB-first into words and buffers them in a show-ahead FIFO.
// Ports: clk_i/reset_i (async active-high); rxd_i serial in; bits_i/baud_i frame
//        config latched per frame; pop_i/ovr_clr_i from the register block;
//        dat_o/not_empty_o/full_o FIFO head and status; idle_o, overrun_o, ferr_o.
// Optional macro SIA_RXQ_SYNC_EN: adds a two-flop synchronizer on rxd_i.
module sia_rxq
    import sia_pkg::*;
#(
    parameter int SHIFT_REG_WIDTH = 12,
    parameter int BAUD_RATE_WIDTH = 32,
    parameter int DEPTH_BITS      = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       rxd_i,
    input  logic [4:0]                 bits_i,
    input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
    input  logic                       pop_i,
    input  logic                       ovr_clr_i,
    output logic [SHIFT_REG_WIDTH-1:0] dat_o,
    output logic                       not_empty_o,
    output logic                       full_o,
    output logic                       idle_o,
    output logic                       overrun_o,
    output logic                       ferr_o
);

    logic rxd;

`ifdef SIA_RXQ_SYNC_EN
    // Reset to the idle-high line level so reset release never looks like a start.
    logic [1:0] sync_q;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], rxd_i};
    end
    assign rxd = sync_q[1];
`else
    assign rxd = rxd_i;
`endif

    rx_state_t                  state_q, state_d;
    logic [BAUD_RATE_WIDTH-1:0] cnt_q,   cnt_d;
    logic [BAUD_RATE_WIDTH-1:0] baud_q,  baud_d;
    logic [4:0]                 bits_q,  bits_d;
    logic [4:0]                 idx_q,   idx_d;
    logic [SHIFT_REG_WIDTH-1:0] sreg_q,  sreg_d;
    logic                       done_q,  done_d;   // final sample taken last edge
    logic                       last_q,  last_d;   // most recent sampled bit
    logic                       push_q,  push_d;
    logic                       ferr_d;
    logic                       sample;
    logic                       fifo_full;
    logic                       fifo_empty;

    assign sample = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            baud_q  <= '0;
            bits_q  <= 5'd1;
            idx_q   <= '0;
            sreg_q  <= '0;
            done_q  <= 1'b0;
            last_q  <= 1'b1;
            push_q  <= 1'b0;
            ferr_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            baud_q  <= baud_d;
            bits_q  <= bits_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
            last_q  <= last_d;
            push_q  <= push_d;
            ferr_o  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        baud_d  = baud_q;
        bits_d  = bits_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        done_d  = 1'b0;
        last_d  = last_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxd) begin
                    state_d = ST_START;
                    bits_d  = (bits_i <= 5'd1) ? 5'd1 : bits_i;
                    baud_d  = baud_i;
                    // Countdown reaches zero (baud>>1)+1 edges later: mid start bit.
                    cnt_d   = baud_i >> 1;
                    sreg_d  = '0;
                    idx_d   = '0;
                end
            end

            ST_START: begin
                if (sample) begin
                    if (rxd) begin
                        state_d = ST_IDLE;            // glitch, not a start bit
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = 5'd1;               // bit 0 already cleared
                        last_d  = 1'b0;
                        cnt_d   = baud_q;
                        done_d  = (bits_q == 5'd1);   // single-bit frame ends here
                    end
                end else begin
                    cnt_d = cnt_q - BAUD_RATE_WIDTH'(1);
                end
            end

            ST_DATA: begin
                if (done_q) begin
                    // Hand the word to the FIFO; a low final bit is a framing error
                    // and the line must return high before the next start.
                    push_d  = 1'b1;
                    ferr_d  = ~last_q;
                    state_d = last_q ? ST_IDLE : ST_WAITHI;
                end else if (sample) begin
                    for (int i = 0; i < SHIFT_REG_WIDTH; i++) begin
                        if (int'(idx_q) == i) sreg_d[i] = rxd;
                    end
                    idx_d  = idx_q + 5'd1;
                    last_d = rxd;
                    cnt_d  = baud_q;
                    done_d = (idx_d == bits_q);
                end else begin
                    cnt_d = cnt_q - BAUD_RATE_WIDTH'(1);
                end
            end

            ST_WAITHI: begin
                if (rxd) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // sreg_q is stable through the push cycle: a new start can only clear it
    // on the same edge that the FIFO captures it.
    sia_fifo #(
        .WIDTH      (SHIFT_REG_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (push_q),
        .wdata (sreg_q),
        .pop   (pop_i),
        .rdata (dat_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign not_empty_o = ~fifo_empty;
    assign full_o      = fifo_full;
    assign idle_o      = (state_q == ST_IDLE);

    // A simultaneous pop makes room, so only an unmatched push into a full FIFO drops.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                         overrun_o <= 1'b0;
        else if (push_q && fifo_full && !pop_i) overrun_o <= 1'b1;
        else if (ovr_clr_i)                  overrun_o <= 1'b0;
    end

endmodule
